// File: rtl/mem_arbiter_if.sv
// Signal bundle between the fetch/load-store requesters, the arbiter and Memory.
// The slave view belongs to the arbiter. The master view belongs to whatever
// drives the requests and supplies Memory's q.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_w;
    logic                  mem_r;
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_q,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_data, mem_w, mem_r, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_q,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_data, mem_w, mem_r, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single-port synchronous Memory between the instruction-fetch port
// (read-only) and the data port (read/write). Each access takes an ISSUE cycle,
// where Memory captures the address or write data, followed by a COMPLETE cycle,
// where Memory updates q on the negedge. The data port has priority, but fetch is
// forced through after STARVE_LIMIT consecutive lost arbitrations.
// All outputs are registered.
module mem_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         starve_cnt, starve_nx;
    logic                  owner_d, owner_d_nx;
    logic                  we, we_nx;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_nx;
    logic                  mem_w_q, mem_w_nx;
    logic                  mem_r_q, mem_r_nx;
    logic                  i_gnt_q, i_gnt_nx;
    logic                  d_gnt_q, d_gnt_nx;
    logic                  i_rvalid_q, i_rvalid_nx;
    logic                  d_rvalid_q, d_rvalid_nx;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_nx;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_nx;
    logic                  busy_q, busy_nx;

    logic arb_edge;
    logic any_req;
    logic data_wins;

    assign arb_edge  = (state == IDLE) || (state == COMPLETE);
    assign any_req   = bus.i_req || bus.d_req;
    assign data_wins = bus.d_req && (!bus.i_req || (starve_cnt < CW'(STARVE_LIMIT)));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, arbitration and next values of every registered output
    always_comb begin
        state_nx    = state;
        starve_nx   = starve_cnt;
        owner_d_nx  = owner_d;
        we_nx       = we;
        addr_nx     = addr_q;
        wdata_nx    = wdata_q;
        mem_w_nx    = 1'b0;
        mem_r_nx    = 1'b0;
        i_gnt_nx    = 1'b0;
        d_gnt_nx    = 1'b0;
        i_rvalid_nx = 1'b0;
        d_rvalid_nx = 1'b0;
        i_rdata_nx  = i_rdata_q;
        d_rdata_nx  = d_rdata_q;

        case (state)
            ISSUE: begin
                state_nx = COMPLETE;
                mem_r_nx = !we;
            end
            COMPLETE: begin
                if (!we) begin
                    if (owner_d) begin
                        d_rdata_nx  = bus.mem_q;
                        d_rvalid_nx = 1'b1;
                    end else begin
                        i_rdata_nx  = bus.mem_q;
                        i_rvalid_nx = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (arb_edge) begin
            state_nx = IDLE;
            if (any_req) begin
                state_nx   = ISSUE;
                owner_d_nx = data_wins;
                we_nx      = data_wins && bus.d_we;
                addr_nx    = data_wins ? bus.d_addr : bus.i_addr;
                wdata_nx   = data_wins ? bus.d_wdata : '0;
                mem_w_nx   = we_nx;
                mem_r_nx   = !we_nx;
                d_gnt_nx   = data_wins;
                i_gnt_nx   = !data_wins;
            end
            starve_nx = (bus.i_req && data_wins) ? starve_cnt + CW'(1) : '0;
        end

        busy_nx = (state_nx != IDLE);
    end

    // Latched access context, starvation counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            owner_d    <= 1'b0;
            we         <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_w_q    <= 1'b0;
            mem_r_q    <= 1'b0;
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            starve_cnt <= starve_nx;
            owner_d    <= owner_d_nx;
            we         <= we_nx;
            addr_q     <= addr_nx;
            wdata_q    <= wdata_nx;
            mem_w_q    <= mem_w_nx;
            mem_r_q    <= mem_r_nx;
            i_gnt_q    <= i_gnt_nx;
            d_gnt_q    <= d_gnt_nx;
            i_rvalid_q <= i_rvalid_nx;
            d_rvalid_q <= d_rvalid_nx;
            i_rdata_q  <= i_rdata_nx;
            d_rdata_q  <= d_rdata_nx;
            busy_q     <= busy_nx;
        end
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_data = wdata_q;
    assign bus.mem_w    = mem_w_q;
    assign bus.mem_r    = mem_r_q;
    assign bus.i_gnt    = i_gnt_q;
    assign bus.d_gnt    = d_gnt_q;
    assign bus.i_rvalid = i_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.busy     = busy_q;
endmodule
